// File: rtl/pmp_prog_ctrl_pkg.sv
// Shared types and helpers for the PMP programming sequencer.
// Provides the response status and FSM state enums, the pmpcfg byte layout,
// CSR base addresses and the byte extract/merge helpers used on cfg words.
// Optional feature macro: PMP_PROG_VERIFY_EN adds a read-back VERIFY state.
package pmp_prog_ctrl_pkg;

    localparam logic [31:0] CSR_PMPCFG0  = 32'h0000_03A0;
    localparam logic [31:0] CSR_PMPADDR0 = 32'h0000_03B0;

    // Address-matching modes of a pmpcfg entry
    localparam logic [1:0] PMP_A_OFF = 2'd0;
    localparam logic [1:0] PMP_A_TOR = 2'd1;

    typedef struct packed {
        logic       l;
        logic [1:0] rsvd;
        logic [1:0] a;
        logic       x;
        logic       w;
        logic       r;
    } pmpcfg_t;

    typedef enum logic [1:0] {
        PMP_ST_OK          = 2'd0,
        PMP_ST_LOCKED      = 2'd1,
        PMP_ST_TOR_LOCKED  = 2'd2,
        PMP_ST_VERIFY_FAIL = 2'd3
    } pmp_status_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_CFG  = 3'd1,
        ST_RD_NXT  = 3'd2,
        ST_CHK     = 3'd3,
        ST_WR_ADDR = 3'd4,
        ST_WR_CFG  = 3'd5,
        ST_RESP    = 3'd6
`ifdef PMP_PROG_VERIFY_EN
        , ST_VERIFY = 3'd7
`endif
    } pmp_prog_state_e;

    // Pick byte 'sel' of a 32-bit pmpcfg word as a structured cfg entry
    function automatic pmpcfg_t cfg_byte(input logic [31:0] word, input logic [1:0] sel);
        pmpcfg_t res;
        case (sel)
            2'd0:    res = pmpcfg_t'(word[7:0]);
            2'd1:    res = pmpcfg_t'(word[15:8]);
            2'd2:    res = pmpcfg_t'(word[23:16]);
            2'd3:    res = pmpcfg_t'(word[31:24]);
            default: res = pmpcfg_t'(8'h00);
        endcase
        return res;
    endfunction

    // Replace byte 'sel' of a pmpcfg word, leaving the other three entries intact
    function automatic logic [31:0] cfg_merge(input logic [31:0] word, input logic [1:0] sel,
                                              input logic [7:0] new_byte);
        logic [31:0] res;
        res = word;
        case (sel)
            2'd0:    res[7:0]   = new_byte;
            2'd1:    res[15:8]  = new_byte;
            2'd2:    res[23:16] = new_byte;
            2'd3:    res[31:24] = new_byte;
            default: res        = word;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/pmp_prog_ctrl.sv
// PMP region programming sequencer.
// One request programs one region: read the cfg word (and the following cfg
// word when the next entry lives there), refuse if the target is locked or the
// next entry is a locked TOR entry, otherwise write pmpaddr then the merged cfg
// word. All outputs are registered and computed from the next state, so the CSR
// strobes line up with the state they belong to.
// Optional feature macro: PMP_PROG_VERIFY_EN re-reads the cfg word after the
// write and reports VERIFY_FAIL when the hardware legalised the byte.
module pmp_prog_ctrl
    import pmp_prog_ctrl_pkg::*;
#(
    parameter int NUM_REGIONS = 16,
    localparam int IDXW = $clog2(NUM_REGIONS)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [IDXW-1:0] req_idx,
    input  logic [31:0]     req_addr,
    input  logic [7:0]      req_cfg,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [1:0]      resp_status,
    output logic            busy,
    output logic            csr_wr_en,
    output logic [31:0]     csr_addr,
    output logic [31:0]     csr_wdata,
    input  logic [31:0]     csr_rdata
);

    pmp_prog_state_e state_q, state_d;
    pmp_status_e     status_q, status_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [31:0]     addr_q, addr_d;
    logic [7:0]      cfg_q, cfg_d;
    logic [31:0]     cfg_word_q, cfg_word_d;
    logic [7:0]      nxt_cfg_q, nxt_cfg_d;

    logic            req_ready_q, req_ready_d;
    logic            resp_valid_q, resp_valid_d;
    logic [1:0]      resp_status_q, resp_status_d;
    logic            busy_q, busy_d;
    logic            csr_wr_en_q, csr_wr_en_d;
    logic [31:0]     csr_addr_q, csr_addr_d;
    logic [31:0]     csr_wdata_q, csr_wdata_d;

    logic            not_last_s;
    logic            need_rd_nxt_s;
    pmpcfg_t         tgt_cfg_s;
    pmpcfg_t         nxt_cfg_s;
    logic [31:0]     cfg_waddr_s;

    // Decode lock-check inputs from the captured cfg words
    always_comb begin
        not_last_s    = (32'(idx_q) < 32'(NUM_REGIONS - 1));
        need_rd_nxt_s = (idx_q[1:0] == 2'b11) && not_last_s;
        tgt_cfg_s     = cfg_byte(cfg_word_q, idx_q[1:0]);
        if (idx_q[1:0] == 2'b11) begin
            nxt_cfg_s = pmpcfg_t'(nxt_cfg_q);
        end else begin
            nxt_cfg_s = cfg_byte(cfg_word_q, idx_q[1:0] + 2'd1);
        end
    end

    // Next-state logic: sequence reads, lock checks, writes and the response
    always_comb begin
        state_d    = state_q;
        status_d   = status_q;
        idx_d      = idx_q;
        addr_d     = addr_q;
        cfg_d      = cfg_q;
        cfg_word_d = cfg_word_q;
        nxt_cfg_d  = nxt_cfg_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    idx_d    = req_idx;
                    addr_d   = req_addr;
                    cfg_d    = req_cfg;
                    status_d = PMP_ST_OK;
                    state_d  = ST_RD_CFG;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_CFG: begin
                cfg_word_d = csr_rdata;
                if (need_rd_nxt_s) begin
                    state_d = ST_RD_NXT;
                end else begin
                    state_d = ST_CHK;
                end
            end
            ST_RD_NXT: begin
                nxt_cfg_d = csr_rdata[7:0];
                state_d   = ST_CHK;
            end
            ST_CHK: begin
                if (tgt_cfg_s.l) begin
                    status_d = PMP_ST_LOCKED;
                    state_d  = ST_RESP;
                end else if (not_last_s && nxt_cfg_s.l && (nxt_cfg_s.a == PMP_A_TOR)) begin
                    status_d = PMP_ST_TOR_LOCKED;
                    state_d  = ST_RESP;
                end else begin
                    state_d = ST_WR_ADDR;
                end
            end
            ST_WR_ADDR: begin
                state_d = ST_WR_CFG;
            end
            ST_WR_CFG: begin
`ifdef PMP_PROG_VERIFY_EN
                state_d = ST_VERIFY;
`else
                status_d = PMP_ST_OK;
                state_d  = ST_RESP;
`endif
            end
`ifdef PMP_PROG_VERIFY_EN
            ST_VERIFY: begin
                if (cfg_byte(csr_rdata, idx_q[1:0]) != pmpcfg_t'(cfg_q)) begin
                    status_d = PMP_ST_VERIFY_FAIL;
                end else begin
                    status_d = PMP_ST_OK;
                end
                state_d = ST_RESP;
            end
`endif
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from the next state so the registered strobes match that state
    always_comb begin
        cfg_waddr_s   = CSR_PMPCFG0 + (32'(idx_d) >> 2);
        csr_wr_en_d   = 1'b0;
        csr_addr_d    = 32'h0000_0000;
        csr_wdata_d   = 32'h0000_0000;
        resp_valid_d  = 1'b0;
        req_ready_d   = (state_d == ST_IDLE);
        busy_d        = (state_d != ST_IDLE);
        resp_status_d = resp_status_q;
        case (state_d)
            ST_RD_CFG: begin
                csr_addr_d = cfg_waddr_s;
            end
            ST_RD_NXT: begin
                csr_addr_d = cfg_waddr_s + 32'd1;
            end
            ST_WR_ADDR: begin
                csr_wr_en_d = 1'b1;
                csr_addr_d  = CSR_PMPADDR0 + 32'(idx_d);
                csr_wdata_d = addr_d;
            end
            ST_WR_CFG: begin
                csr_wr_en_d = 1'b1;
                csr_addr_d  = cfg_waddr_s;
                csr_wdata_d = cfg_merge(cfg_word_d, idx_d[1:0], cfg_d);
            end
`ifdef PMP_PROG_VERIFY_EN
            ST_VERIFY: begin
                csr_addr_d = cfg_waddr_s;
            end
`endif
            ST_RESP: begin
                resp_valid_d  = 1'b1;
                resp_status_d = status_d;
            end
            default: begin
                csr_wr_en_d = 1'b0;
            end
        endcase
    end

    // State, request context and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            status_q      <= PMP_ST_OK;
            idx_q         <= '0;
            addr_q        <= 32'h0000_0000;
            cfg_q         <= 8'h00;
            cfg_word_q    <= 32'h0000_0000;
            nxt_cfg_q     <= 8'h00;
            req_ready_q   <= 1'b1;
            resp_valid_q  <= 1'b0;
            resp_status_q <= 2'd0;
            busy_q        <= 1'b0;
            csr_wr_en_q   <= 1'b0;
            csr_addr_q    <= 32'h0000_0000;
            csr_wdata_q   <= 32'h0000_0000;
        end else begin
            state_q       <= state_d;
            status_q      <= status_d;
            idx_q         <= idx_d;
            addr_q        <= addr_d;
            cfg_q         <= cfg_d;
            cfg_word_q    <= cfg_word_d;
            nxt_cfg_q     <= nxt_cfg_d;
            req_ready_q   <= req_ready_d;
            resp_valid_q  <= resp_valid_d;
            resp_status_q <= resp_status_d;
            busy_q        <= busy_d;
            csr_wr_en_q   <= csr_wr_en_d;
            csr_addr_q    <= csr_addr_d;
            csr_wdata_q   <= csr_wdata_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign resp_valid  = resp_valid_q;
    assign resp_status = resp_status_q;
    assign busy        = busy_q;
    assign csr_wr_en   = csr_wr_en_q;
    assign csr_addr    = csr_addr_q;
    assign csr_wdata   = csr_wdata_q;

endmodule
